// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_responder
// Description : Memory-side responder for the data SRAM-like interface.
//               Accepts requests into an in-order queue, performs writes at
//               acceptance against a word-addressed backing array, samples
//               reads at acceptance, and answers each request with a single
//               data_ok pulse after a minimum latency.
// Options     : RESP_STALL_EN - LFSR-driven random acceptance stalls and
//               per-request extra latency (0..3 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int QDEPTH      = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(QDEPTH + 1);
   // Wide enough for LATENCY-1 plus the largest stall extension.
   localparam int WW = 5;
   localparam logic [CW-1:0] QDEPTH_C  = CW'(QDEPTH);
   localparam logic [WW-1:0] WAIT_INIT = WW'(LATENCY - 1);

   logic [31:0]               mem [DEPTH_WORDS];
   logic [AW-1:0]             index;
   logic                      accept;
   logic                      pop;
   logic                      stall;
   logic [WW-1:0]             extra;
   logic [CW-1:0]             count;
   logic [CW-1:0]             count_nxt;
   logic [CW-1:0]             slot;
   logic [QDEPTH-1:0]         q_valid;
   logic [QDEPTH-1:0]         q_read;
   logic [QDEPTH-1:0]         n_valid;
   logic [QDEPTH-1:0]         n_read;
   logic [QDEPTH-1:0][31:0]   q_data;
   logic [QDEPTH-1:0][31:0]   n_data;
   logic [QDEPTH-1:0][WW-1:0] q_wait;
   logic [QDEPTH-1:0][WW-1:0] n_wait;
   logic [QDEPTH-1:0][WW-1:0] dec_wait;
   logic                      resp_nxt;
   logic                      unused_bits;

   // Size and out-of-range address bits carry no meaning here.
   assign unused_bits = &{1'b0, data_sram_size, data_sram_addr[31:AW+2], data_sram_addr[1:0]};

   assign index = data_sram_addr[AW+1:2];

`ifdef RESP_STALL_EN
   logic [7:0] lfsr;

   // Free-running Fibonacci LFSR (taps 8,6,5,4) that gates acceptance and stretches latency.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign stall = lfsr[0];
   assign extra = {{(WW-2){1'b0}}, lfsr[2:1]};
`else
   assign stall = 1'b0;
   assign extra = '0;
`endif

   // Acceptance depends only on registered occupancy, never on req or a same-cycle retire.
   assign data_sram_addr_ok = resetn && (count < QDEPTH_C) && !stall;
   assign accept            = data_sram_req && data_sram_addr_ok;

   // The head retires in exactly the cycle data_ok is high.
   assign pop  = q_valid[0] && (q_wait[0] == '0);
   assign slot = count - CW'(pop);

   // Next queue image: age every entry, shift out a retiring head, append the new request.
   always_comb begin
      dec_wait = q_wait;
      for (int i = 0; i < QDEPTH; i++) begin
         if (q_wait[i] != '0) begin
            dec_wait[i] = q_wait[i] - WW'(1);
         end
      end
      n_valid = pop ? (q_valid >> 1) : q_valid;
      n_read  = pop ? (q_read >> 1) : q_read;
      n_data  = pop ? (q_data >> 32) : q_data;
      n_wait  = pop ? (dec_wait >> WW) : dec_wait;
      if (accept) begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (slot == CW'(i)) begin
               n_valid[i] = 1'b1;
               n_read[i]  = !data_sram_wr;
               n_data[i]  = data_sram_wr ? 32'h0 : mem[index];
               n_wait[i]  = WAIT_INIT + extra;
            end
         end
      end
      count_nxt = count + CW'(accept) - CW'(pop);
      resp_nxt  = n_valid[0] && (n_wait[0] == '0);
   end

   // Queue state and registered response outputs; reset drops anything in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count             <= '0;
         q_valid           <= '0;
         q_read            <= '0;
         q_data            <= '0;
         q_wait            <= '0;
         data_sram_data_ok <= 1'b0;
         data_sram_rdata   <= 32'h0;
      end else begin
         count             <= count_nxt;
         q_valid           <= n_valid;
         q_read            <= n_read;
         q_data            <= n_data;
         q_wait            <= n_wait;
         data_sram_data_ok <= resp_nxt;
         if (resp_nxt && n_read[0]) begin
            data_sram_rdata <= n_data[0];
         end
      end
   end

   // Byte-enabled write into the backing array at the acceptance edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (accept && data_sram_wr) begin
         if (data_sram_wstrb[0]) mem[index][7:0]   <= data_sram_wdata[7:0];
         if (data_sram_wstrb[1]) mem[index][15:8]  <= data_sram_wdata[15:8];
         if (data_sram_wstrb[2]) mem[index][23:16] <= data_sram_wdata[23:16];
         if (data_sram_wstrb[3]) mem[index][31:24] <= data_sram_wdata[31:24];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_responder
// Description : Scoreboard bench for data_sram_responder. The driver pushes
//               the expected response (data and due cycle) at acceptance; a
//               monitor checks addr_ok, data_ok timing and rdata every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_responder;

   localparam int DEPTH_WORDS = 1024;
   localparam int LATENCY     = 2;
   localparam int QDEPTH      = 2;

   logic        clk    = 1'b0;
   logic        resetn = 1'b1;
   logic        req    = 1'b0;
   logic        wr     = 1'b0;
   logic [1:0]  size   = 2'd2;
   logic [3:0]  wstrb  = 4'h0;
   logic [31:0] addr   = 32'h0;
   logic [31:0] wdata  = 32'h0;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   data_sram_responder #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .LATENCY     (LATENCY),
      .QDEPTH      (QDEPTH)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .data_sram_req     (req),
      .data_sram_wr      (wr),
      .data_sram_size    (size),
      .data_sram_wstrb   (wstrb),
      .data_sram_addr    (addr),
      .data_sram_wdata   (wdata),
      .data_sram_addr_ok (addr_ok),
      .data_sram_data_ok (data_ok),
      .data_sram_rdata   (rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit          rd;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [DEPTH_WORDS];
   logic [31:0] last_rd  = 32'h0;
   int          last_due = -1;

`ifdef RESP_STALL_EN
   logic [7:0] lfsr_m;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) lfsr_m <= 8'hA5;
      else         lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   end
`endif

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference behaviour at acceptance: memory update / sample and the due cycle.
   task automatic record_accept();
      exp_t e;
      int   idx;
      int   lat;
      idx    = int'((addr >> 2) % DEPTH_WORDS);
      e.rd   = !wr;
      e.data = 32'h0;
      if (wr) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
         e.data = ref_mem[idx];
      end
      lat = LATENCY;
`ifdef RESP_STALL_EN
      lat = lat + int'(lfsr_m[2:1]);
`endif
      e.due = cyc + lat;
      if (e.due <= last_due) e.due = last_due + 1;
      last_due = e.due;
      sb.push_back(e);
   endtask

   // Present a request and hold it until accepted; returns at the accepting negedge.
   task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit done;
      done = 1'b0;
      @(posedge clk); #1;
      req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
      for (int k = 0; k < 64 && !done; k++) begin
         @(negedge clk);
         if (addr_ok === 1'b1) begin
            record_accept();
            done = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!done) begin
         chk(done, "accept_timeout", 32'(done), 32'h1);
         req = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         req = 1'b0;
         @(negedge clk);
      end
   endtask

   // Called at a negedge; asserts reset asynchronously mid-cycle.
   task automatic do_reset(input int n);
      #1;
      resetn   = 1'b0;
      req      = 1'b0;
      sb.delete();
      last_due = -1;
      last_rd  = 32'h0;
      repeat (n) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
   endtask

   // Monitor: compares outputs of each cycle against the scoreboard head.
   always @(posedge clk) begin
      bit   exp_aok;
      bit   exp_dok;
      exp_t e;
      #3;
      if (!resetn) begin
         chk(data_ok === 1'b0, "reset_data_ok", 32'(data_ok), 32'h0);
         chk(rdata === 32'h0, "reset_rdata", rdata, 32'h0);
         chk(addr_ok === 1'b0, "reset_addr_ok", 32'(addr_ok), 32'h0);
      end else begin
         exp_aok = (sb.size() < QDEPTH);
`ifdef RESP_STALL_EN
         exp_aok = exp_aok && !lfsr_m[0];
`endif
         chk(addr_ok === exp_aok, "addr_ok", 32'(addr_ok), 32'(exp_aok));
         exp_dok = (sb.size() > 0) && (sb[0].due == cyc);
         chk(data_ok === exp_dok, "data_ok", 32'(data_ok), 32'(exp_dok));
         if (data_ok === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.rd) begin
               chk(rdata === e.data, "read_rdata", rdata, e.data);
               last_rd = e.data;
            end else begin
               chk(rdata === last_rd, "write_rdata_hold", rdata, last_rd);
            end
         end else if (sb.size() > 0 && sb[0].due < cyc) begin
            chk(1'b0, "late_response", 32'(sb[0].due), 32'(cyc));
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] up;
      int          idx;
      #2;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);

      // Word write then read back.
      issue(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
      idle(3);
      issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      idle(3);
      // Single byte lane update.
      issue(1'b1, 32'h0000_1000, 32'h00AA_0000, 4'b0100);
      idle(3);
      issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      idle(3);
      // Address wrap, then an all-zero strobe that must not modify memory.
      issue(1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF);
      issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      issue(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'h0);
      issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);
      idle(4);
      // Three back-to-back reads fill the two-entry queue.
      issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      idle(5);
      // Reset with two reads in flight.
      issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
      issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);
      do_reset(3);
      idle(3);

      // Initialise a small working set of words, with random upper address bits.
      for (int i = 0; i < 16; i++) begin
         up = $urandom() & 32'hFFFF_F000;
         issue(1'b1, up | 32'(i << 2), $urandom(), 4'hF);
      end
      // Random mix of reads and writes with random gaps.
      for (int n = 0; n < 200; n++) begin
         up  = $urandom() & 32'hFFFF_F000;
         idx = $urandom_range(0, 15);
         issue(1'($urandom_range(0, 1)), up | 32'(idx << 2) | 32'($urandom_range(0, 3)),
               $urandom(), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      for (int k = 0; k < 100 && sb.size() > 0; k++) idle(1);
      chk(sb.size() == 0, "drain", 32'(sb.size()), 32'h0);
      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_sram_responder.md
# data_sram_responder

Memory-side responder for the data SRAM-like interface driven by the EX stage and consumed by the MEM stage. It accepts requests with `data_sram_addr_ok` and stores them in an in-order queue. Writes go into a word-addressed backing array, and reads sample it. Each request gets a single-cycle `data_sram_data_ok` pulse with `data_sram_rdata` after a fixed minimum latency. It is the bench/SoC-side counterpart of the pipeline's `data_sram_data_ok`/`data_sram_rdata` consumer.

## Interface
- `DEPTH_WORDS`, 1024: backing array size in 32-bit words; power of two.
- `LATENCY`, 2: minimum cycles from acceptance to `data_ok`; range 1..15.
- `QDEPTH`, 2: maximum outstanding accepted-but-unanswered requests; range 1..8.

- `clk`  in  1  clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `data_sram_req`  in  1  request valid.
- `data_sram_wr`  in  1  1 = write, 0 = read.
- `data_sram_size`  in  2  access size. Informational only; the strobe governs the write.
- `data_sram_wstrb`  in  4  byte write enables. Ignored for reads.
- `data_sram_addr`  in  32  byte address.
- `data_sram_wdata`  in  32  write data.
- `data_sram_addr_ok`  out  1  request accepted this cycle when high together with `req`.
- `data_sram_data_ok`  out  1  one-cycle response pulse, one per accepted request, in order.
- `data_sram_rdata`  out  32  read data; valid in the `data_ok` cycle of a read.

## Operation
- Acceptance: `req && addr_ok` in cycle T accepts the request. `addr_ok = resetn && (count < QDEPTH)`. `count` is registered occupancy, so `addr_ok` does not depend combinationally on `req` or on a same-cycle retire.
- Index: `addr[2+log2(DEPTH_WORDS)-1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH_WORDS*4`.
- Write: performed at the acceptance edge, per byte where `wstrb[i]=1`. `wstrb=0` writes nothing but still receives `data_ok`.
- Read: the array is sampled at the acceptance edge. A read therefore sees every write accepted before it, and does not see later writes.
- Queue entry contents: `{is_read, rdata, wait}`. `wait` is a countdown that reaches 0 no earlier than cycle T+LATENCY.
- Retire: at most one entry per cycle, from the head only. The head retires when it is valid and its own latency has elapsed. Retiring drives `data_ok=1` for exactly one cycle.
  - On a read retire, `rdata` loads the entry's data.
  - On a write retire, `rdata` holds its previous value.
- Consumer readiness: the consumer has no ready signal and always takes `data_ok`. The block never stretches `data_ok`.
- Accept and retire in the same cycle: `count` stays the same. When the queue is full, the accept is impossible because `addr_ok=0`.
- Reset, asynchronous assert at any time, including mid-operation:
  - `count`, all queue entries and LFSR state clear.
  - Pending responses are dropped.
  - `data_ok=0`, `rdata=32'h0`, `addr_ok=0` while `resetn` is low.
  - Array contents are not reset.

## Timing
- Minimum latency: request accepted in cycle T gives `data_ok` high in cycle T+LATENCY when the queue ahead of it is empty.
- Back-to-back: requests accepted in T and T+1 respond in T+LATENCY and T+LATENCY+1. A request never responds before its own T+LATENCY, and never before all earlier requests.
- Occupancy: `count` increments at the accept edge and decrements at the edge ending the `data_ok` cycle. A slot freed by a retire in cycle R makes `addr_ok` high in R+1.
- Registered outputs: `data_ok` and `rdata` come from flops. `addr_ok` is a function of registered state and `resetn` only.
- Reset release: first possible acceptance is in the first cycle with `resetn` high.

## Configuration
- Macro: `RESP_STALL_EN`.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to `8'hA5` on reset and shifts every cycle.
  - `addr_ok = resetn && (count < QDEPTH) && !lfsr[0]`.
  - Each entry's latency becomes `LATENCY + lfsr[2:1]`, sampled at acceptance.
  - Ordering and one-pulse-per-request rules still hold.
- Undefined: no LFSR. `addr_ok` depends on occupancy only, and latency is exactly `LATENCY`.

## Test plan
- Word write/read: write `0x0000_1000 = 0xDEADBEEF`, `wstrb=4'hF`, then read `0x1000` accepted in cycle T (LATENCY=2) -> `data_ok` in T+2, `rdata=0xDEADBEEF`.
- Byte strobe: after the above, write `wdata=0x00AA0000`, `wstrb=4'b0100`, then read `0x1000` -> `rdata=0xDEAABEEF`. The write's `data_ok` leaves `rdata` unchanged.
- Queue full (QDEPTH=2, LATENCY=2): reads in T, T+1, with `req` held -> `addr_ok=0` in T+2, third request accepted in T+3, `data_ok` high in T+2, T+3 and T+5.
- Address wrap (DEPTH_WORDS=1024): write `0x0000_0000 = 0x12345678`, read `0x0000_1000` -> `rdata=0x12345678`.
- Async reset mid-flight: two reads outstanding, `resetn` low for 3 cycles -> no `data_ok` during or after reset, `addr_ok=0` while low, `addr_ok=1` first cycle after release.
- `RESP_STALL_EN`: 64 random reads/writes with `req` held -> `addr_ok` follows `!lfsr[0]` from seed `0xA5`, every request gets exactly one in-order `data_ok`, and read data matches the reference model.
